// File: rtl/rst_seq_gen.sv
// Reset sequencer: asserts all channels, releases them one at a time in index
// order, then waits for link-up and tracks link health in RUN.
module rst_seq_gen #(
    parameter int              N_CH     = 2,
    parameter int              CNT_W    = 16,
    parameter int              HOLD_CYC = 16,
    parameter logic [N_CH-1:0] ACT_LOW  = 2'b10,
    parameter int              LINK_TMO = 1000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            sw_rst,
    input  logic            link_up,
    output logic [N_CH-1:0] rst_out,
    output logic            seq_done,
    output logic            link_tmo,
    output logic [2:0]      state
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((LINK_TMO > 0) ? LINK_TMO - 1 : 0);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
    localparam bit               WAIT_EN   = (LINK_TMO != 0);

    typedef enum logic [2:0] {
        S_ASSERT  = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_RUN     = 3'd3,
        S_FAIL    = 3'd4
    } st_t;

    st_t             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [N_CH-1:0]  rst_q, rst_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            ch_q    <= '0;
            rst_q   <= ~ACT_LOW;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        if (sw_rst) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            wcnt_d  = '0;
            ch_d    = '0;
            rst_d   = ~ACT_LOW;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    rst_d = ~ACT_LOW;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                        ch_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[ch_q] = ACT_LOW[ch_q];
                        cnt_d       = '0;
                        if (ch_q == CH_LAST) begin
                            ch_d   = '0;
                            wcnt_d = '0;
                            // With the wait disabled, skip straight to RUN.
                            if (WAIT_EN) begin
                                state_d = S_WAIT;
                            end else begin
                                state_d = S_RUN;
                                done_d  = 1'b1;
                            end
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    rst_d = ACT_LOW;
                    // link_up beats a timeout landing on the same edge.
                    if (link_up) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                        wcnt_d  = '0;
                    end else if (wcnt_q == TMO_LAST) begin
                        state_d = S_FAIL;
                        tmo_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    rst_d = ACT_LOW;
                    if (!link_up && WAIT_EN) begin
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                S_FAIL: begin
                    rst_d = ACT_LOW;
                    tmo_d = 1'b1;
                end
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    ch_d    = '0;
                    rst_d   = ~ACT_LOW;
                end
            endcase
        end
    end

    assign rst_out  = rst_q;
    assign seq_done = done_q;
    assign link_tmo = tmo_q;
    assign state    = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default instance plus a 4-channel,
// HOLD_CYC=1, no-link-wait instance.
module tb_rst_seq_gen;

    logic       CLK = 1'b0;
    logic       RESET, sw_rst, link_up;
    logic [1:0] rst_out;
    logic       seq_done, link_tmo;
    logic [2:0] state;

    logic       rst2, sw2, lu2;
    logic [3:0] rst_out2;
    logic       seq_done2, link_tmo2;
    logic [2:0] state2;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    always #5 CLK = ~CLK;

    rst_seq_gen dut (
        .CLK(CLK), .RESET(RESET), .sw_rst(sw_rst), .link_up(link_up),
        .rst_out(rst_out), .seq_done(seq_done), .link_tmo(link_tmo), .state(state)
    );

    rst_seq_gen #(.N_CH(4), .CNT_W(16), .HOLD_CYC(1), .ACT_LOW(4'b0000), .LINK_TMO(0)) dut2 (
        .CLK(CLK), .RESET(rst2), .sw_rst(sw2), .link_up(lu2),
        .rst_out(rst_out2), .seq_done(seq_done2), .link_tmo(link_tmo2), .state(state2)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
        e++;
    endtask

    task automatic tick_to(input int k);
        while (e < k) tick();
    endtask

    // Last edge that samples RESET=1 is labelled edge 0.
    task automatic do_reset;
        RESET = 1'b1; rst2 = 1'b1; sw_rst = 1'b0; sw2 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        e = 0;
        RESET = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; rst2 = 1'b1; sw_rst = 1'b1; sw2 = 1'b0; link_up = 1'b1; lu2 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++;
        if (rst_out !== 2'b01) begin n_fail++; $display("FAIL reset_rst_out: got %b want 01", rst_out); end
        n_checks++;
        if (seq_done !== 1'b0 || link_tmo !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got done=%b tmo=%b want 0 0", seq_done, link_tmo);
        end
        n_checks++;
        if (rst_out2 !== 4'b1111 || state2 !== 3'd0) begin
            n_fail++; $display("FAIL reset_dut2: got rst=%b st=%0d want 1111 0", rst_out2, state2);
        end
        sw_rst = 1'b0;
    endtask

    task automatic test_nominal;
        logic [1:0] x_rst;
        logic [2:0] x_st;
        logic       x_done;
        link_up = 1'b0;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            if (k == 40) link_up = 1'b1;
            tick();
            x_rst  = (k < 32) ? 2'b01 : (k < 48) ? 2'b00 : 2'b10;
            x_st   = (k < 16) ? 3'd0 : (k < 48) ? 3'd1 : (k == 48) ? 3'd2 : 3'd3;
            x_done = (k >= 49);
            n_checks++;
            if (rst_out !== x_rst || state !== x_st || seq_done !== x_done || link_tmo !== 1'b0) begin
                n_fail++;
                $display("FAIL nominal edge %0d: got rst=%b st=%0d done=%b tmo=%b want rst=%b st=%0d done=%b tmo=0",
                         e, rst_out, state, seq_done, link_tmo, x_rst, x_st, x_done);
            end
        end
    endtask

    task automatic test_timeout;
        link_up = 1'b0;
        do_reset();
        tick_to(1047);
        n_checks++;
        if (state !== 3'd2 || link_tmo !== 1'b0) begin
            n_fail++; $display("FAIL tmo_before edge %0d: got st=%0d tmo=%b want 2 0", e, state, link_tmo);
        end
        tick_to(1048);
        n_checks++;
        if (state !== 3'd4 || link_tmo !== 1'b1 || rst_out !== 2'b10 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_hit edge %0d: got st=%0d tmo=%b rst=%b done=%b want 4 1 10 0",
                     e, state, link_tmo, rst_out, seq_done);
        end
        // FAIL must ignore a late link_up.
        link_up = 1'b1;
        tick_to(1055);
        n_checks++;
        if (state !== 3'd4 || link_tmo !== 1'b1 || rst_out !== 2'b10) begin
            n_fail++; $display("FAIL tmo_sticky: got st=%0d tmo=%b rst=%b want 4 1 10", state, link_tmo, rst_out);
        end
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        n_checks++;
        if (state !== 3'd0 || link_tmo !== 1'b0 || rst_out !== 2'b01 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_sw_exit: got st=%0d tmo=%b rst=%b done=%b want 0 0 01 0",
                     state, link_tmo, rst_out, seq_done);
        end
    endtask

    task automatic test_sw_rst_mid;
        link_up = 1'b1;
        do_reset();
        tick_to(40);
        n_checks++;
        if (rst_out !== 2'b00 || state !== 3'd1) begin
            n_fail++; $display("FAIL swmid_pre: got rst=%b st=%0d want 00 1", rst_out, state);
        end
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        n_checks++;
        if (rst_out !== 2'b01 || state !== 3'd0) begin
            n_fail++; $display("FAIL swmid_41: got rst=%b st=%0d want 01 0", rst_out, state);
        end
        tick_to(72);
        n_checks++;
        if (rst_out !== 2'b01) begin n_fail++; $display("FAIL swmid_72: got %b want 01", rst_out); end
        tick_to(73);
        n_checks++;
        if (rst_out !== 2'b00) begin n_fail++; $display("FAIL swmid_73: got %b want 00", rst_out); end
        tick_to(88);
        n_checks++;
        if (rst_out !== 2'b00) begin n_fail++; $display("FAIL swmid_88: got %b want 00", rst_out); end
        tick_to(89);
        n_checks++;
        if (rst_out !== 2'b10 || state !== 3'd2) begin
            n_fail++; $display("FAIL swmid_89: got rst=%b st=%0d want 10 2", rst_out, state);
        end
        tick_to(90);
        n_checks++;
        if (state !== 3'd3 || seq_done !== 1'b1) begin
            n_fail++; $display("FAIL swmid_90: got st=%0d done=%b want 3 1", state, seq_done);
        end
    endtask

    // Continues from RUN left by test_sw_rst_mid.
    task automatic test_link_drop;
        link_up = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (state !== 3'd2 || seq_done !== 1'b0 || rst_out !== 2'b10) begin
                n_fail++;
                $display("FAIL drop_%0d: got st=%0d done=%b rst=%b want 2 0 10", k, state, seq_done, rst_out);
            end
        end
        link_up = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd3 || seq_done !== 1'b1 || rst_out !== 2'b10) begin
            n_fail++; $display("FAIL drop_back: got st=%0d done=%b rst=%b want 3 1 10", state, seq_done, rst_out);
        end
    endtask

    task automatic test_four_ch;
        logic [3:0] x_rst;
        logic [2:0] x_st;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int i = 0; i < 4; i++) x_rst[i] = (k >= i + 2) ? 1'b0 : 1'b1;
            x_st = (k < 5) ? 3'd1 : 3'd3;
            n_checks++;
            if (rst_out2 !== x_rst || state2 !== x_st || seq_done2 !== (k >= 5) || link_tmo2 !== 1'b0) begin
                n_fail++;
                $display("FAIL four_ch edge %0d: got rst=%b st=%0d done=%b want rst=%b st=%0d done=%b",
                         e, rst_out2, state2, seq_done2, x_rst, x_st, (k >= 5));
            end
        end
    endtask

    task automatic test_reset_priority;
        link_up = 1'b1;
        do_reset();
        tick_to(55);
        n_checks++;
        if (state !== 3'd3) begin n_fail++; $display("FAIL prio_run: got %0d want 3", state); end
        RESET = 1'b1; sw_rst = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd0 || rst_out !== 2'b01 || seq_done !== 1'b0 || link_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_reset: got st=%0d rst=%b done=%b tmo=%b want 0 01 0 0",
                     state, rst_out, seq_done, link_tmo);
        end
        e = 0;
        RESET = 1'b0; sw_rst = 1'b0;
        tick_to(15);
        n_checks++;
        if (state !== 3'd0 || rst_out !== 2'b01) begin
            n_fail++; $display("FAIL prio_15: got st=%0d rst=%b want 0 01", state, rst_out);
        end
        tick_to(16);
        n_checks++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL prio_16: got %0d want 1", state); end
        tick_to(32);
        n_checks++;
        if (rst_out !== 2'b00) begin n_fail++; $display("FAIL prio_32: got %b want 00", rst_out); end
        tick_to(48);
        n_checks++;
        if (rst_out !== 2'b10 || state !== 3'd2) begin
            n_fail++; $display("FAIL prio_48: got rst=%b st=%0d want 10 2", rst_out, state);
        end
        tick_to(49);
        n_checks++;
        if (state !== 3'd3 || seq_done !== 1'b1) begin
            n_fail++; $display("FAIL prio_49: got st=%0d done=%b want 3 1", state, seq_done);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_four_ch();
        test_timeout();
        test_sw_rst_mid();
        test_link_drop();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, the number of reset channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the stage and timeout counters.
REQ-003 The block SHALL have parameter HOLD_CYC, default 16, the cycles per sequencing stage (1..2^CNT_W-1).
REQ-004 The block SHALL have parameter ACT_LOW, default 2'b10 (N_CH bits), where bit i=1 makes channel i active-low (PERST#-style).
REQ-005 The block SHALL have parameter LINK_TMO, default 1000, the link-up wait limit in cycles (0 disables the wait; max 2^CNT_W-1).
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port sw_rst, input, 1 bit: single-cycle request to restart the sequence.
REQ-009 The block SHALL have port link_up, input, 1 bit: link-trained status from the link model.
REQ-010 The block SHALL have port rst_out, output, N_CH bits: per-channel reset, polarity per ACT_LOW.
REQ-011 The block SHALL have port seq_done, output, 1 bit: high in RUN only.
REQ-012 The block SHALL have port link_tmo, output, 1 bit: sticky link-up timeout flag.
REQ-013 The block SHALL have port state, output, 3 bits: ASSERT=0, RELEASE=1, WAIT_LINK=2, RUN=3, FAIL=4.

Function
REQ-014 In every state, "asserted" for channel i SHALL mean rst_out[i]=~ACT_LOW[i], and "released" SHALL mean rst_out[i]=ACT_LOW[i]; all outputs SHALL be registered.
REQ-015 ASSERT SHALL hold all channels asserted for HOLD_CYC cycles, with stage counter cnt running 0..HOLD_CYC-1, then enter RELEASE with cnt=0 and ch_idx=0.
REQ-016 RELEASE SHALL release channel ch_idx when cnt==HOLD_CYC-1, then increment ch_idx and clear cnt.
REQ-017 After channel N_CH-1 is released, RELEASE SHALL go to WAIT_LINK, or go directly to RUN if LINK_TMO==0.
REQ-018 With RESET released at edge 0, channel i SHALL release at edge HOLD_CYC*(i+2); release SHALL be strictly ordered 0..N_CH-1.
REQ-019 WAIT_LINK SHALL count cycles from 0; link_up=1 SHALL go to RUN on the next edge.
REQ-020 If the WAIT_LINK count reaches LINK_TMO-1 with link_up=0, the block SHALL go to FAIL and set link_tmo=1.
REQ-021 If link_up rises on the same edge that the timeout is reached, link_up SHALL win and the block SHALL go to RUN.
REQ-022 RUN SHALL hold seq_done=1; link_up falling SHALL return the block to WAIT_LINK with the count cleared and seq_done=0, and channels SHALL stay released.
REQ-023 FAIL SHALL keep channels released and link_tmo=1, and SHALL be left only via sw_rst or RESET.
REQ-024 sw_rst=1 in any state, including mid-ASSERT or mid-RELEASE, SHALL on the next edge assert all channels, enter ASSERT with cnt=0 and ch_idx=0, clear seq_done, and clear link_tmo.
REQ-025 Counters SHALL never wrap: cnt SHALL be bounded by HOLD_CYC-1 and the WAIT_LINK count by LINK_TMO-1.
REQ-026 Invalid state encodings 5..7 SHALL go to ASSERT on the next edge.

Reset
REQ-027 While RESET=1, the block SHALL set state=ASSERT, all channels asserted, cnt=0, ch_idx=0, wait count=0, seq_done=0 and link_tmo=0.
REQ-028 RESET SHALL take priority over sw_rst and link_up.
REQ-029 Asserting RESET mid-sequence SHALL reassert all channels on the next edge.

Verification
REQ-030 Defaults, RESET released at edge 0 with link_up=1 from edge 40: rst_out=2'b01 until edge 32, 2'b00 until edge 48, 2'b10 from edge 48; state goes 0->1 at edge 16, 1->2 at 48, 2->3 at 49; seq_done=1 at 49.
REQ-031 Defaults with link_up held 0: link_tmo=1 and state=4 at edge 1048; rst_out stays 2'b10.
REQ-032 Inject sw_rst at edge 40 (mid-RELEASE): rst_out=2'b01 at edge 41; channel 0 releases at edge 73, channel 1 at edge 89.
REQ-033 In RUN, drop link_up for 5 cycles: state goes to 2, seq_done=0, and rst_out stays 2'b10; state returns to 3 one edge after link_up rises again.
REQ-034 With N_CH=4, ACT_LOW=0, HOLD_CYC=1, LINK_TMO=0: channels release at edges 2, 3, 4, 5 in order; state=3 at edge 5.
REQ-035 Assert RESET and sw_rst together in RUN: the block reaches the RESET state of REQ-027, and the sequence restarts exactly as in REQ-030 once RESET is released.
